// File: rtl/apb_regfile_slave_pkg.sv
// Shared types and constants for the APB register-file completer.
// Holds the FSM state encoding and the fixed register indices.
package apb_slave_pkg;

  typedef enum logic {IDLE, ACCESS} apb_slv_state_e;

  localparam int          REG_ID_IDX   = 0;
  localparam int          REG_XFER_IDX = 1;
  localparam logic [31:0] MISS_RDATA   = 32'h0;

endpackage

// File: rtl/apb_regfile_slave.sv
// APB completer with a word-addressed register bank, fixed wait states,
// a read-only ID word at index 0 and a read-only transfer counter at index 1.
module apb_regfile_slave
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
  // access cycles (psel=1, penable=1); it completes on the edge where
  // pready=1 is sampled together with psel & penable. Dropping psel in
  // the access phase abandons the transfer with no side effects.

  apb_slv_state_e state, state_d;
  logic [3:0]     cnt;
  logic [31:0]    xfer_cnt;
  logic [31:0]    addr_q;
  logic           write_q;
  logic [31:0]    wdata_q;
  logic [31:0]    regs [NUM_REGS];

  logic           setup, step, complete, abort;
  logic [31:0]    rd_addr;
  logic           rd_write;
  logic [IDX_W-1:0] rd_idx;
  logic           rd_hit;
  logic [31:0]    rd_data;
  logic           commit;
  logic [1:0]     unused_addr_lsb;

  assign unused_addr_lsb = paddr[1:0] ^ addr_q[1:0];

  always_comb begin
    state_d  = state;
    setup    = 1'b0;
    step     = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          setup   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (penable && pready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (penable) begin
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states pready rises on the setup edge, so the read value
  // must come straight from the bus rather than from the latched address.
  always_comb begin
    rd_addr  = (state == IDLE) ? paddr  : addr_q;
    rd_write = (state == IDLE) ? pwrite : write_q;
    rd_idx   = rd_addr[IDX_W+1:2];
    rd_hit   = (rd_addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    rd_data  = MISS_RDATA;
    if (rd_write)
      rd_data = 32'h0;
    else if (rd_hit) begin
      if (rd_idx == IDX_W'(REG_ID_IDX))
        rd_data = ID_VALUE;
      else if (rd_idx == IDX_W'(REG_XFER_IDX))
        rd_data = xfer_cnt;
      else
        rd_data = regs[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      pready   <= 1'b0;
      prdata   <= 32'h0;
      xfer_cnt <= 32'h0;
      addr_q   <= 32'h0;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0;
    end else begin
      state <= state_d;
      if (setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        cnt     <= 4'(WAIT_CYCLES);
        pready  <= (WAIT_CYCLES == 0);
        prdata  <= (WAIT_CYCLES == 0) ? rd_data : 32'h0;
      end else if (step) begin
        cnt    <= cnt - 4'd1;
        pready <= (cnt == 4'd1);
        prdata <= (cnt == 4'd1) ? rd_data : 32'h0;
      end else if (complete) begin
        xfer_cnt <= xfer_cnt + 32'd1;
        pready   <= 1'b0;
        prdata   <= 32'h0;
      end else if (abort) begin
        pready <= 1'b0;
        prdata <= 32'h0;
      end
    end
  end

  // Indices 0 and 1 are read-only; only the RW range is ever written.
  assign commit = complete && write_q && rd_hit &&
                  (rd_idx != IDX_W'(REG_ID_IDX)) && (rd_idx != IDX_W'(REG_XFER_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else if (commit) begin
      regs[rd_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed plus randomized bench for apb_regfile_slave: a 2-wait-state instance
// checked against a register-map model, and a 0-wait-state instance for back-to-back timing.
module tb_apb_regfile_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel0, penable0, pwrite0, pready0;
  logic [31:0] paddr0, pwdata0, prdata0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_cnt;
  logic [31:0] exp_q [$];

  apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0), .ID_VALUE(ID)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0), .ID_VALUE(ID)) dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
    .paddr(paddr0), .pwdata(pwdata0), .prdata(prdata0), .pready(pready0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_bus(input bit on0, input logic s, input logic e, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (on0) begin psel0 = s; penable0 = e; pwrite0 = w; paddr0 = a; pwdata0 = d; end
    else     begin psel  = s; penable  = e; pwrite  = w; paddr  = a; pwdata  = d; end
  endtask

  function automatic logic get_ready(input bit on0);
    return on0 ? pready0 : pready;
  endfunction

  function automatic logic [31:0] get_rdata(input bit on0);
    return on0 ? prdata0 : prdata;
  endfunction

  // Starts with the setup phase immediately; returns one #1 after the completion edge.
  task automatic xfer(input bit on0, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int acc);
    bit done;
    set_bus(on0, 1'b1, 1'b0, wr, addr, wd);
    @(posedge clk); #1;
    set_bus(on0, 1'b1, 1'b1, wr, $urandom, $urandom);
    acc = 0; done = 0; rd = 32'h0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      acc++;
      if (get_ready(on0)) begin
        done = 1;
        rd = get_rdata(on0);
      end else
        check("prdata_wait", get_rdata(on0), 32'h0);
    end
    if (!done) check("pready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    set_bus(on0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx;
    if (addr[31:6] != 26'h0) return 32'h0;
    idx = int'(addr[5:2]);
    if (idx == 0) return ID;
    if (idx == 1) return m_cnt;
    return m_regs[idx];
  endfunction

  task automatic chk_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    int acc;
    int idx;
    exp_q.push_back(wr ? 32'h0 : model_read(addr));
    xfer(1'b0, wr, addr, wd, rd, acc);
    check(wr ? "wr_prdata" : "rd_prdata", rd, exp_q.pop_front());
    check("latency", 32'(acc), 32'd3);
    idx = int'(addr[5:2]);
    if (wr && addr[31:6] == 26'h0 && idx >= 2) m_regs[idx] = wd;
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_cnt = 32'h0;
  endtask

  initial begin
    logic [31:0] rd;
    int acc;
    int t0;
    logic [31:0] a;

    rst_n = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pready", {31'h0, pready}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready0", {31'h0, pready0}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk_xfer(1'b0, 32'h08, 32'h0);
    chk_xfer(1'b0, 32'h00, 32'h0);

    chk_xfer(1'b1, 32'h08, 32'hCAFE_F00D);
    chk_xfer(1'b0, 32'h08, 32'h0);

    chk_xfer(1'b1, 32'h00, 32'h1234_5678);
    chk_xfer(1'b1, 32'h40, 32'h1234_5678);
    chk_xfer(1'b0, 32'h00, 32'h0);
    chk_xfer(1'b0, 32'h40, 32'h0);
    chk_xfer(1'b0, 32'h04, 32'h0);

    // penable without a setup phase must not start a transfer
    set_bus(1'b0, 1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("noset_pready", {31'h0, pready}, 32'h0);
    end
    @(posedge clk); #1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // abort in the first access cycle of a write
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_pready", {31'h0, pready}, 32'h0);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) begin
      @(negedge clk);
      check("abort_idle_pready", {31'h0, pready}, 32'h0);
    end
    @(posedge clk); #1;
    chk_xfer(1'b0, 32'h0C, 32'h0);
    chk_xfer(1'b0, 32'h04, 32'h0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) a = 32'h40 * $urandom_range(1, 8);
      else a = 32'h4 * $urandom_range(0, 15);
      a = a | 32'($urandom_range(0, 3));
      chk_xfer(1'($urandom_range(0, 1)), a, $urandom);
    end

    // counter wrap
    force dut.xfer_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    m_cnt = 32'hFFFF_FFFF;
    chk_xfer(1'b0, 32'h04, 32'h0);
    chk_xfer(1'b0, 32'h04, 32'h0);

    // zero-wait-state instance: back-to-back writes, no idle gap
    @(posedge clk); #1;
    t0 = cyc;
    xfer(1'b1, 1'b1, 32'h08, 32'h1111_2222, rd, acc);
    check("b2b_lat0", 32'(acc), 32'd1);
    xfer(1'b1, 1'b1, 32'h0C, 32'h3333_4444, rd, acc);
    check("b2b_lat1", 32'(acc), 32'd1);
    check("b2b_cycles", 32'(cyc - t0), 32'd4);
    xfer(1'b1, 1'b0, 32'h08, 32'h0, rd, acc);
    check("b2b_rd08", rd, 32'h1111_2222);
    xfer(1'b1, 1'b0, 32'h0C, 32'h0, rd, acc);
    check("b2b_rd0c", rd, 32'h3333_4444);

    // reset asserted while pready is high
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h5555_AAAA);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_pready", {31'h0, pready}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_pready", {31'h0, pready}, 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_xfer(1'b0, 32'h10, 32'h0);
    chk_xfer(1'b0, 32'h04, 32'h0);
    chk_xfer(1'b0, 32'h00, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
